// File: rtl/ifetch_queue.sv
// ----------------------------------------------------------------------------
// ifetch_queue
//
// Instruction fetch front end with a decoupling prefetch queue. It owns the
// fetch PC and issues in-order word reads to a variable-latency instruction
// memory. Returned words are buffered together with their addresses and handed
// to the IF stage over a valid/ready handshake. A redirect (branch, jump,
// exception) restarts fetch at a new PC and discards every fetch still owed by
// the memory for the old path.
//
// Parameters
//   DEPTH     queue entries and maximum outstanding requests (power of two, 2..16)
//   RESET_PC  fetch address after reset
//
// Ports
//   clk             clock, all state updates on the rising edge
//   rst_n           synchronous active-low reset
//   redirect_valid  flush and restart fetch at redirect_pc
//   redirect_pc     new fetch address, bits [1:0] ignored
//   imem_req_valid  read request valid
//   imem_req_ready  memory accepts the request
//   imem_req_addr   word-aligned request address
//   imem_rsp_valid  read data valid (in request order, >= 1 cycle after accept)
//   imem_rsp_data   read data
//   out_valid       instruction available to IF
//   out_ready       IF accepts the instruction
//   out_ins         instruction word
//   out_pc          address of out_ins
//
// Build option
//   IFQ_BYPASS_EN   when defined, a response arriving at an empty queue is
//                   presented on out_* in the same cycle (0-cycle latency).
//                   When undefined, out_* come only from queue registers.
// ----------------------------------------------------------------------------
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_ins,
    output logic [31:0] out_pc
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_C = SW'(DEPTH);

    logic [31:0]   fetch_pc_q,  fetch_pc_d;
    logic [CW-1:0] in_flight_q, in_flight_d;
    logic [CW-1:0] drop_cnt_q,  drop_cnt_d;
    logic [CW-1:0] count_q,     count_d;
    logic [PW-1:0] tag_wr_q,    tag_wr_d;
    logic [PW-1:0] tag_rd_q,    tag_rd_d;
    logic [PW-1:0] wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0] rd_ptr_q,    rd_ptr_d;

    logic [31:0]   tag_mem_q [DEPTH];
    logic [31:0]   pc_mem_q  [DEPTH];
    logic [31:0]   ins_mem_q [DEPTH];

    logic [SW-1:0] credit_used;
    logic          req_fire;
    logic          rsp_keep;
    logic          head_valid;
    logic          push;
    logic          pop;
    logic [31:0]   rsp_pc;
    logic [31:0]   head_pc;
    logic [31:0]   head_ins;
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A slot is reserved for every outstanding request, so queued plus
    // in-flight words can never exceed DEPTH and a response always has room.
    assign credit_used    = {1'b0, in_flight_q} + {1'b0, count_q};
    assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_C);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // The address tag of the oldest outstanding request pairs with the
    // response that is arriving now, since the memory answers in order.
    assign rsp_pc   = tag_mem_q[tag_rd_q];
    assign rsp_keep = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;

    // An empty queue drives zeros so the outputs are defined out of reset.
    assign head_valid = (count_q != '0);
    assign head_pc    = head_valid ? pc_mem_q[rd_ptr_q]  : 32'h0;
    assign head_ins   = head_valid ? ins_mem_q[rd_ptr_q] : 32'h0;
    assign pop        = head_valid && out_ready;

`ifdef IFQ_BYPASS_EN
    logic bypass;

    // A kept response meeting an empty queue goes straight to IF; it is only
    // written into the queue if IF does not take it this cycle.
    assign bypass    = rsp_keep && !head_valid;
    assign push      = rsp_keep && !(bypass && out_ready);
    assign out_valid = head_valid || bypass;
    assign out_pc    = bypass ? rsp_pc        : head_pc;
    assign out_ins   = bypass ? imem_rsp_data : head_ins;
`else
    assign push      = rsp_keep;
    assign out_valid = head_valid;
    assign out_pc    = head_pc;
    assign out_ins   = head_ins;
`endif

    // Next-state logic. A redirect overrides the normal bookkeeping: the
    // queue is emptied and every response still owed for the old path is
    // marked for dropping. Using the outstanding total (rather than adding to
    // the old drop count) keeps back-to-back redirects from double counting,
    // because in_flight already includes responses that were already doomed.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        in_flight_d = in_flight_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_cnt_d  = drop_cnt_q;
        count_d     = count_q + CW'(push) - CW'(pop);
        tag_wr_d    = tag_wr_q + PW'(req_fire);
        tag_rd_d    = tag_rd_q + PW'(imem_rsp_valid);
        wr_ptr_d    = wr_ptr_q + PW'(push);
        rd_ptr_d    = rd_ptr_q + PW'(pop);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (imem_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
        end

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            drop_cnt_d = in_flight_q - CW'(imem_rsp_valid);
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end
    end

    // Control state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            in_flight_q <= '0;
            drop_cnt_q  <= '0;
            count_q     <= '0;
            tag_wr_q    <= '0;
            tag_rd_q    <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            in_flight_q <= in_flight_d;
            drop_cnt_q  <= drop_cnt_d;
            count_q     <= count_d;
            tag_wr_q    <= tag_wr_d;
            tag_rd_q    <= tag_rd_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage arrays need no reset; validity is tracked by the pointers and
    // counters above.
    always_ff @(posedge clk) begin
        if (req_fire) begin
            tag_mem_q[tag_wr_q] <= fetch_pc_q;
        end
        if (push) begin
            pc_mem_q[wr_ptr_q]  <= rsp_pc;
            ins_mem_q[wr_ptr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// ----------------------------------------------------------------------------
// tb_ifetch_queue
//
// Self-checking bench for ifetch_queue. A simple in-order memory with a
// configurable latency answers the DUT's requests. A transaction-level model
// tracks the expected fetch PC, the list of outstanding requests tagged with
// the redirect epoch they were issued in, and the queue of deliverable
// instructions. Every cycle the DUT outputs are compared against that model.
// Directed sequences add literal expectations for the key scenarios, then a
// long randomized run exercises redirects, stalls and resets.
// ----------------------------------------------------------------------------
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ins;
    logic [31:0] out_pc;

    ifetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_ins        (out_ins),
        .out_pc         (out_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epoch;
    } outst_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } memreq_t;

    // Model state
    logic [31:0] mPc;
    logic [31:0] epoch;
    outst_t      mOut[$];
    ent_t        mQ[$];

    // Memory environment state
    memreq_t     memQ[$];
    int          lastDue;
    int          latMin;
    int          latMax;

    // Drive values for the next cycle
    logic        drvRst;
    logic        drvRedirect;
    logic [31:0] drvRedirPc;
    logic        drvReqReady;
    logic        drvOutReady;

    // Bookkeeping
    int          cyc;
    int          rstCycles;
    int          acceptCount;
    logic [31:0] dutLog[$];
    int          nCompares;
    int          nMiscompares;

    function automatic logic [31:0] memFn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompares++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chkLog(input string name, input int idx, input logic [31:0] exp);
        nCompares++;
        if (dutLog.size() <= idx) begin
            nMiscompares++;
            $display("[TB] FAIL %s: entry %0d missing (only %0d delivered), expected %h",
                     name, idx, dutLog.size(), exp);
        end else if (dutLog[idx] !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: entry %0d got %h, expected %h", name, idx, dutLog[idx], exp);
        end
    endtask

    // Drive the DUT inputs shortly after the falling edge and let them settle.
    task automatic applyStimulus();
        @(negedge clk);
        rst_n          = drvRst;
        redirect_valid = drvRedirect;
        redirect_pc    = drvRedirPc;
        imem_req_ready = drvReqReady;
        out_ready      = drvOutReady;
        if (drvRst && memQ.size() > 0 && memQ[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memFn(memQ[0].addr);
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        #1;
    endtask

    // Compare the settled outputs against the model, then advance the model
    // and the memory to the state they will have after the coming edge.
    task automatic checkOutput();
        bit          expReqV;
        bit          rspKeep;
        bit          byp;
        bit          expOutV;
        ent_t        e;
        outst_t      o;
        memreq_t     m;
        int          due;

        if (!rst_n) begin
            chk("reqValidInReset", 32'(imem_req_valid), 32'd0);
            if (rstCycles > 0) begin
                chk("outValidInReset", 32'(out_valid), 32'd0);
                chk("outInsInReset", out_ins, 32'd0);
                chk("outPcInReset", out_pc, 32'd0);
            end
            rstCycles++;
            mPc = RESET_PC;
            mOut.delete();
            mQ.delete();
            memQ.delete();
            lastDue = 0;
            epoch   = epoch + 32'd1;
            cyc++;
            return;
        end
        rstCycles = 0;

        expReqV = !redirect_valid && ((mOut.size() + mQ.size()) < DEPTH);
        chk("reqValid", 32'(imem_req_valid), 32'(expReqV));
        if (expReqV) chk("reqAddr", imem_req_addr, mPc);

        rspKeep = imem_rsp_valid && (mOut.size() > 0) && (mOut[0].epoch == epoch) && !redirect_valid;
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = rspKeep && (mQ.size() == 0);
`endif
        expOutV = (mQ.size() != 0) || byp;
        chk("outValid", 32'(out_valid), 32'(expOutV));
        if (byp) begin
            chk("outPc", out_pc, mOut[0].pc);
            chk("outIns", out_ins, memFn(mOut[0].pc));
        end else if (expOutV) begin
            chk("outPc", out_pc, mQ[0].pc);
            chk("outIns", out_ins, mQ[0].ins);
        end

        if (out_valid === 1'b1 && out_ready) dutLog.push_back(out_pc);

        if (expOutV && out_ready && !byp) mQ.delete(0);

        if (imem_rsp_valid) begin
            if (rspKeep && !(byp && out_ready)) begin
                e.pc  = mOut[0].pc;
                e.ins = memFn(mOut[0].pc);
                mQ.push_back(e);
            end
            if (mOut.size() > 0) mOut.delete(0);
            if (memQ.size() > 0) memQ.delete(0);
        end

        if (expReqV && imem_req_ready) begin
            o.pc    = mPc;
            o.epoch = epoch;
            mOut.push_back(o);
            mPc = mPc + 32'd4;
        end

        if (imem_req_valid === 1'b1 && imem_req_ready) begin
            acceptCount++;
            due = cyc + int'($urandom_range(latMax, latMin));
            if (due <= lastDue) due = lastDue + 1;
            m.addr = imem_req_addr;
            m.due  = due;
            memQ.push_back(m);
            lastDue = due;
        end

        if (redirect_valid) begin
            mQ.delete();
            epoch = epoch + 32'd1;
            mPc   = {redirect_pc[31:2], 2'b00};
        end

        cyc++;
    endtask

    task automatic cycle();
        applyStimulus();
        checkOutput();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic doReset();
        drvRst      = 1'b0;
        drvRedirect = 1'b0;
        cycles(2);
        drvRst = 1'b1;
    endtask

    // Stop issuing, let all outstanding reads return and the queue drain.
    task automatic quiesce();
        drvRedirect = 1'b0;
        drvReqReady = 1'b0;
        drvOutReady = 1'b1;
        cycles(12);
    endtask

    initial begin
        nCompares    = 0;
        nMiscompares = 0;
        cyc          = 0;
        rstCycles    = 0;
        acceptCount  = 0;
        epoch        = 32'd0;
        mPc          = RESET_PC;
        lastDue      = 0;
        latMin       = 1;
        latMax       = 1;
        drvRst       = 1'b0;
        drvRedirect  = 1'b0;
        drvRedirPc   = 32'h0;
        drvReqReady  = 1'b1;
        drvOutReady  = 1'b1;

        $display("[TB] reset and streaming with 1-cycle memory");
        cycles(3);
        drvRst = 1'b1;
        applyStimulus();
        chk("firstReqValid", 32'(imem_req_valid), 32'd1);
        chk("firstReqAddr", imem_req_addr, RESET_PC);
        chk("firstOutValid", 32'(out_valid), 32'd0);
        chk("firstOutIns", out_ins, 32'd0);
        chk("firstOutPc", out_pc, 32'd0);
        checkOutput();
        cycles(11);
        for (int i = 0; i < 8; i++) chkLog("streamPc", i, 32'(4 * i));
        dutLog.delete();
        cycles(20);
        nCompares++;
        if (dutLog.size() != 20) begin
            nMiscompares++;
            $display("[TB] FAIL throughput: got %0d instructions in 20 cycles, expected 20", dutLog.size());
        end
        for (int i = 1; i < 20; i++) chkLog("streamContig", i, dutLog[0] + 32'(4 * i));

        $display("[TB] back-pressure fills the queue");
        doReset();
        drvOutReady = 1'b0;
        drvReqReady = 1'b1;
        acceptCount = 0;
        cycles(19);
        applyStimulus();
        chk("fullReqValid", 32'(imem_req_valid), 32'd0);
        checkOutput();
        chk("fullAccepts", 32'(acceptCount), 32'd4);
        dutLog.delete();
        drvOutReady = 1'b1;
        cycles(10);
        for (int i = 0; i < 4; i++) chkLog("drainPc", i, 32'(4 * i));

        $display("[TB] redirect with two requests in flight, latency 3");
        doReset();
        latMin = 3;
        latMax = 3;
        dutLog.delete();
        drvReqReady = 1'b1;
        cycles(2);
        drvReqReady = 1'b0;
        drvRedirect = 1'b1;
        drvRedirPc  = 32'h0000_0100;
        cycle();
        drvRedirect = 1'b0;
        drvReqReady = 1'b1;
        applyStimulus();
        chk("postRedirReqValid", 32'(imem_req_valid), 32'd1);
        chk("postRedirReqAddr", imem_req_addr, 32'h0000_0100);
        chk("postRedirOutValid", 32'(out_valid), 32'd0);
        checkOutput();
        cycles(12);
        chkLog("redirFirstPc", 0, 32'h0000_0100);

        $display("[TB] redirect coinciding with a response");
        doReset();
        latMin = 2;
        latMax = 2;
        dutLog.delete();
        drvReqReady = 1'b1;
        cycles(2);
        drvReqReady = 1'b0;
        drvRedirect = 1'b1;
        drvRedirPc  = 32'h0000_0040;
        cycle();
        drvRedirect = 1'b0;
        drvReqReady = 1'b1;
        applyStimulus();
        chk("coincideOutValid1", 32'(out_valid), 32'd0);
        checkOutput();
        applyStimulus();
        chk("coincideOutValid2", 32'(out_valid), 32'd0);
        checkOutput();
        cycles(10);
        chkLog("coincideFirstPc", 0, 32'h0000_0040);

        $display("[TB] redirect alignment and PC wrap");
        latMin = 1;
        latMax = 1;
        quiesce();
        drvRedirect = 1'b1;
        drvRedirPc  = 32'h0000_0203;
        cycle();
        drvRedirect = 1'b0;
        applyStimulus();
        chk("alignReqValid", 32'(imem_req_valid), 32'd1);
        chk("alignReqAddr", imem_req_addr, 32'h0000_0200);
        checkOutput();
        drvRedirect = 1'b1;
        drvRedirPc  = 32'hFFFF_FFFC;
        cycle();
        drvRedirect = 1'b0;
        drvReqReady = 1'b1;
        dutLog.delete();
        applyStimulus();
        chk("wrapReqAddr0", imem_req_addr, 32'hFFFF_FFFC);
        checkOutput();
        applyStimulus();
        chk("wrapReqAddr1", imem_req_addr, 32'h0000_0000);
        checkOutput();
        cycles(6);
        chkLog("wrapPc0", 0, 32'hFFFF_FFFC);
        chkLog("wrapPc1", 1, 32'h0000_0000);

`ifdef IFQ_BYPASS_EN
        $display("[TB] bypass from an empty queue");
        quiesce();
        drvRedirect = 1'b1;
        drvRedirPc  = 32'h0000_0080;
        cycle();
        drvRedirect = 1'b0;
        drvReqReady = 1'b1;
        cycle();
        drvReqReady = 1'b0;
        applyStimulus();
        chk("bypassOutValid", 32'(out_valid), 32'd1);
        chk("bypassOutPc", out_pc, 32'h0000_0080);
        chk("bypassOutIns", out_ins, memFn(32'h0000_0080));
        checkOutput();
        applyStimulus();
        chk("bypassNoPush", 32'(out_valid), 32'd0);
        checkOutput();
`endif

        $display("[TB] randomized traffic");
        for (int ph = 0; ph < 30; ph++) begin
            int pReq;
            int pOut;
            int pRedir;
            latMin = int'($urandom_range(2, 1));
            latMax = latMin + int'($urandom_range(4, 0));
            pReq   = int'($urandom_range(100, 30));
            pOut   = int'($urandom_range(100, 20));
            pRedir = int'($urandom_range(10, 0));
            if (ph % 10 == 9) doReset();
            for (int c = 0; c < 100; c++) begin
                drvReqReady = ($urandom_range(100, 1) <= pReq);
                drvOutReady = ($urandom_range(100, 1) <= pOut);
                if (drvRedirect && ($urandom_range(2, 0) == 0)) drvRedirect = 1'b1;
                else drvRedirect = ($urandom_range(100, 1) <= pRedir);
                case ($urandom_range(3, 0))
                    0:       drvRedirPc = $urandom;
                    1:       drvRedirPc = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
                    2:       drvRedirPc = 32'($urandom_range(255, 0));
                    default: drvRedirPc = $urandom & 32'h0000_FFFF;
                endcase
                cycle();
            end
        end
        quiesce();

        $display("== %0d vectors applied, %0d miscompares ==", nCompares, nMiscompares);
        $finish;
    end

endmodule
